// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 encodings, FSM states, status codes.
// Pure declarations, no logic.
// Imported by lsu and lsu_align.
package lsu_pkg;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Completion status
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store replication/strobes, load shift/extend, fault detection.
// Purely combinational, zero latency.
// No backpressure; the FSM in lsu decides when results are used.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic        illegal,
  output logic        misalign,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  // Classify funct3: unsigned variants exist only for loads; size bits gate alignment.
  always_comb begin
    illegal  = 1'b0;
    misalign = 1'b0;
    case (req_funct3)
      LB, LH, LW: illegal = 1'b0;
      LBU, LHU:   illegal = req_we;
      default:    illegal = 1'b1;
    endcase
    if (req_funct3[1:0] == 2'b01)
      misalign = req_off[0];
    else if (req_funct3[1:0] == 2'b10)
      misalign = (req_off != 2'b00);
  end

  // Replicate store data across lanes and select the byte strobes; loads drive nothing.
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = 32'h0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          st_wstrb = 4'b0001 << req_off;
          st_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          st_wstrb = 4'b0011 << {req_off[1], 1'b0};
          st_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          st_wstrb = 4'b1111;
          st_wdata = req_wdata;
        end
      endcase
    end
  end

  // Bring the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    shifted = ld_word >> {ld_off, 3'b000};
    case (ld_funct3)
      LB:      ld_data = {{24{shifted[7]}}, shifted[7:0]};
      LH:      ld_data = {{16{shifted[15]}}, shifted[15:0]};
      LW:      ld_data = shifted;
      LBU:     ld_data = {24'h0, shifted[7:0]};
      LHU:     ld_data = {16'h0, shifted[15:0]};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: validates, issues one data-memory access, returns extended data.
// Latency 3 cycles minimum (accept, BUSY, DONE) plus one per memory wait cycle; faults take 2.
// Holds stall while an access is outstanding; mem_valid waits on mem_ready up to TIMEOUT_CYCLES.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST_C = TO_LAST[CW-1:0];

  state_t      state;
  logic [CW-1:0] cnt;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_off_q;
  logic        illegal;
  logic        misalign;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  lsu_align u_align (
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_off    (req_addr[1:0]),
    .req_wdata  (req_wdata),
    .illegal    (illegal),
    .misalign   (misalign),
    .st_wstrb   (st_wstrb),
    .st_wdata   (st_wdata),
    .ld_funct3  (ld_funct3_q),
    .ld_off     (ld_off_q),
    .ld_word    (mem_rdata),
    .ld_data    (ld_data)
  );

  // Status decodes straight off the state register; reset also masks the IDLE stall path.
  assign mem_valid = (state == ST_BUSY);
  assign done      = (state == ST_DONE);
  assign stall     = reset & (((state == ST_IDLE) & req_valid) | (state == ST_BUSY));

  // Access FSM with timeout counter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ld_funct3_q <= 3'b000;
      ld_off_q    <= 2'b00;
      mem_addr    <= 32'h0;
      mem_we      <= 1'b0;
      mem_wstrb   <= 4'b0000;
      mem_wdata   <= 32'h0;
      rdata       <= 32'h0;
      err         <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            if (illegal) begin
              err   <= ERR_ILLEGAL;
              rdata <= 32'h0;
              state <= ST_DONE;
            end else if (misalign) begin
              err   <= ERR_MISALIGN;
              rdata <= 32'h0;
              state <= ST_DONE;
            end else begin
              mem_addr    <= {req_addr[31:2], 2'b00};
              mem_we      <= req_we;
              mem_wstrb   <= st_wstrb;
              mem_wdata   <= st_wdata;
              ld_funct3_q <= req_funct3;
              ld_off_q    <= req_addr[1:0];
              state       <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            rdata <= mem_we ? 32'h0 : ld_data;
            err   <= ERR_NONE;
            state <= ST_DONE;
          end else if (TIMEOUT_CYCLES != 0) begin
            if (cnt == TO_LAST_C) begin
              rdata <= 32'h0;
              err   <= ERR_TIMEOUT;
              state <= ST_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stimulus pushes expectations, monitors pop and compare.
// Memory responder answers after a per-transaction number of wait cycles.
// Summary line reports comparisons and miscompares.
module tb_lsu;
  import lsu_pkg::*;

  typedef struct packed {
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done;
  logic [31:0] rdata;
  logic [1:0]  err;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int vectors = 0;
  int miscompares = 0;
  int cfg_wait = 0;
  logic [31:0] cfg_rword = 32'h0;
  mreq_t mq[$];
  resp_t rq[$];

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rdata(rdata), .err(err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: raise mem_ready on the (cfg_wait+1)-th BUSY cycle.
  initial begin
    int busy_cnt;
    busy_cnt  = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_rdata = cfg_rword;
      if (mem_valid) begin
        mem_ready = (busy_cnt == cfg_wait);
        busy_cnt++;
      end else begin
        mem_ready = 1'b0;
        busy_cnt  = 0;
      end
    end
  end

  // Monitor: compare each new memory request and each completion against the queues.
  initial begin
    logic mv_prev;
    mreq_t em;
    resp_t er;
    mv_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (mem_valid && !mv_prev) begin
        if (mq.size() == 0) begin
          chk("unexpected_mem_req", 32'h1, 32'h0);
        end else begin
          em = mq.pop_front();
          chk("mem_addr", mem_addr, em.addr);
          chk("mem_we", {31'h0, mem_we}, {31'h0, em.we});
          chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, em.wstrb});
          chk("mem_wdata", mem_wdata, em.wdata);
        end
      end
      mv_prev = mem_valid;
      if (done) begin
        if (rq.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          er = rq.pop_front();
          chk("rdata", rdata, er.rdata);
          chk("err", {30'h0, err}, {30'h0, er.err});
        end
      end
    end
  end

  // One instruction: push expectations, hold req_valid until done, check timing.
  task automatic run_op(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rword, input int waits,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                        input logic exp_req, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdat, input int exp_lat, input int exp_mv);
    int stalls, mvc, lat;
    logic got;
    mreq_t m;
    resp_t r;
    stalls = 0; mvc = 0; lat = 0; got = 1'b0;
    m.we = we; m.wstrb = exp_strb; m.addr = {addr[31:2], 2'b00}; m.wdata = exp_wdat;
    r.rdata = exp_rdata; r.err = exp_err;
    @(negedge clk);
    if (exp_req) mq.push_back(m);
    rq.push_back(r);
    cfg_wait = waits; cfg_rword = rword;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (done) begin
        got = 1'b1;
        lat = c;
        break;
      end
      if (stall) stalls++;
      if (mem_valid) mvc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk({name, "_done_seen"}, {31'h0, got}, 32'h1);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_stall_cycles"}, stalls, exp_lat);
    chk({name, "_mem_valid_cycles"}, mvc, exp_mv);
    @(negedge clk);
    #1;
    chk({name, "_rdata_hold"}, rdata, exp_rdata);
    chk({name, "_done_low"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    mreq_t m;
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    #1;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {30'h0, err}, 32'h0);
    chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    //     name    we   f3      addr          wdata         rword         wt   rdata         err           req  strb     wdat          lat mv
    run_op("sw",   1, SW,     32'h100, 32'hDEADBEEF, 32'h0,        0, 32'h0,        ERR_NONE,     1, 4'b1111, 32'hDEADBEEF, 2, 1);
    run_op("lb",   0, LB,     32'h103, 32'h0,        32'h80FF7F01, 3, 32'hFFFFFF80, ERR_NONE,     1, 4'b0000, 32'h0,        5, 4);
    run_op("lbu",  0, LBU,    32'h103, 32'h0,        32'h80FF7F01, 3, 32'h00000080, ERR_NONE,     1, 4'b0000, 32'h0,        5, 4);
    run_op("sh",   1, SH,     32'h102, 32'h1234ABCD, 32'h0,        1, 32'h0,        ERR_NONE,     1, 4'b1100, 32'hABCDABCD, 3, 2);
    run_op("lh_hi",0, LH,     32'h102, 32'h0,        32'h7FFF0000, 0, 32'h00007FFF, ERR_NONE,     1, 4'b0000, 32'h0,        2, 1);
    run_op("lh_lo",0, LH,     32'h100, 32'h0,        32'h12348001, 0, 32'hFFFF8001, ERR_NONE,     1, 4'b0000, 32'h0,        2, 1);
    run_op("lhu",  0, LHU,    32'h100, 32'h0,        32'h12348001, 0, 32'h00008001, ERR_NONE,     1, 4'b0000, 32'h0,        2, 1);
    run_op("sb",   1, SB,     32'h102, 32'h000000A5, 32'h0,        0, 32'h0,        ERR_NONE,     1, 4'b0100, 32'hA5A5A5A5, 2, 1);
    run_op("lw",   0, LW,     32'h200, 32'h0,        32'hCAFEF00D, 2, 32'hCAFEF00D, ERR_NONE,     1, 4'b0000, 32'h0,        4, 3);
    run_op("lw_mis",0,LW,     32'h101, 32'h0,        32'h0,        0, 32'h0,        ERR_MISALIGN, 0, 4'b0000, 32'h0,        1, 0);
    run_op("ld_ill",0,3'b011, 32'h100, 32'h0,        32'h0,        0, 32'h0,        ERR_ILLEGAL,  0, 4'b0000, 32'h0,        1, 0);
    run_op("st_ill",1,3'b100, 32'h100, 32'h0,        32'h0,        0, 32'h0,        ERR_ILLEGAL,  0, 4'b0000, 32'h0,        1, 0);
    run_op("sh_mis",1,SH,     32'h101, 32'h0,        32'h0,        0, 32'h0,        ERR_MISALIGN, 0, 4'b0000, 32'h0,        1, 0);
    run_op("lw_ok2",0,LW,     32'h204, 32'h0,        32'h0BADF00D, 0, 32'h0BADF00D, ERR_NONE,     1, 4'b0000, 32'h0,        2, 1);
    run_op("tmo",  0, LW,     32'h200, 32'h0,        32'h55555555, 1000, 32'h0,     ERR_TIMEOUT,  1, 4'b0000, 32'h0,        5, 4);
    run_op("tmo_race",0,LW,   32'h204, 32'h0,        32'h0BADF00D, 3, 32'h0BADF00D, ERR_NONE,     1, 4'b0000, 32'h0,        5, 4);

    // Abandon a store in its second BUSY cycle via async reset.
    @(negedge clk);
    m.we = 1'b1; m.wstrb = 4'b1111; m.addr = 32'h300; m.wdata = 32'h11223344;
    mq.push_back(m);
    cfg_wait = 1000; cfg_rword = 32'h0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = SW; req_addr = 32'h300; req_wdata = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_mid_busy_before", {31'h0, mem_valid}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("rst_mid_stall", {31'h0, stall}, 32'h0);
    chk("rst_mid_done", {31'h0, done}, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_stall", {31'h0, stall}, 32'h0);
    chk("post_rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    run_op("sw_after_rst", 1, SW, 32'h104, 32'h0F0F0F0F, 32'h0, 0, 32'h0, ERR_NONE, 1, 4'b1111, 32'h0F0F0F0F, 2, 1);

    repeat (3) @(negedge clk);
    chk("mem_queue_drained", mq.size(), 32'h0);
    chk("resp_queue_drained", rq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
